// File: rtl/uart_tx_serializer_if.sv
// Read-side handshake between a latency-1 TX sync FIFO and its serializer.
// master = serializer (issues rd_en), slave = FIFO (returns data qualified by data_valid).
interface uart_tx_serializer_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_data_valid;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  fifo_data_valid,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output fifo_data_valid,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one word from a latency-1 FIFO and shifts it out as a start/data/stop frame.
// Defining UART_TX_PARITY_EN adds a parity bit after the data bits (PARITY_ODD selects odd parity).
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit          PARITY_ODD   = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_serializer_if.master fifo_if,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IdxW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);
  localparam logic            StopLast = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_serializer: DATA_BITS must be in 5..8");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StWaitData,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      baud_q, baud_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 rd_en;
  logic                 done;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign bit_end = (baud_q == BaudLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    rd_en   = 1'b0;
    done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // The baud counter only runs in bit-timed states and wraps at every bit boundary.
    if (state_q != StIdle && state_q != StWaitData) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (!fifo_if.fifo_empty && !reset) begin
          rd_en   = 1'b1;
          state_d = StWaitData;
        end
      end
      StWaitData: begin
        if (fifo_if.fifo_data_valid) begin
          shift_d = fifo_if.fifo_dout;
          baud_d  = '0;
          state_d = StStart;
`ifdef UART_TX_PARITY_EN
          parity_d = (^fifo_if.fifo_dout) ^ PARITY_ODD;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IdxLast) begin
            idx_d  = '0;
            stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          stop_d  = 1'b0;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (stop_q == StopLast) begin
            done    = 1'b1;
            stop_d  = 1'b0;
            state_d = StIdle;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // tx is derived from next-state values so the pin changes on the same edge as the state.
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign fifo_if.fifo_rd_en = rd_en;
  assign tx                 = tx_q;
  assign busy               = (state_q != StIdle);
  assign tx_done            = done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: two DUTs (1 and 2 stop bits) each fed by a latency-1 FIFO model.
module tb_uart_tx_serializer;
  localparam int Cpb = 4;
`ifdef UART_TX_PARITY_EN
  localparam int ParEn = 1;
`else
  localparam int ParEn = 0;
`endif
  localparam int Fl0 = Cpb * (1 + 8 + ParEn + 1);
  localparam int Fl1 = Cpb * (1 + 8 + ParEn + 2);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_serializer_if #(.DATA_BITS(8)) if_a ();
  uart_tx_serializer_if #(.DATA_BITS(8)) if_b ();
  logic tx_a, busy_a, done_a, tx_b, busy_b, done_b;

  uart_tx_serializer #(
    .CLKS_PER_BIT(Cpb), .DATA_BITS(8), .STOP_BITS(1)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD(1'b0)
`endif
  ) u_dut_a (
    .clk(clk), .reset(reset), .fifo_if(if_a), .tx(tx_a), .busy(busy_a), .tx_done(done_a)
  );

  uart_tx_serializer #(
    .CLKS_PER_BIT(Cpb), .DATA_BITS(8), .STOP_BITS(2)
`ifdef UART_TX_PARITY_EN
    , .PARITY_ODD(1'b1)
`endif
  ) u_dut_b (
    .clk(clk), .reset(reset), .fifo_if(if_b), .tx(tx_b), .busy(busy_b), .tx_done(done_b)
  );

  // Latency-1 FIFO models
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  int wr_a, rd_a, pops_a, wr_b, rd_b, pops_b;
  assign if_a.fifo_empty = (wr_a == rd_a);
  assign if_b.fifo_empty = (wr_b == rd_b);

  always @(posedge clk) begin
    if (reset) if_a.fifo_data_valid <= 1'b0;
    else       if_a.fifo_data_valid <= if_a.fifo_rd_en;
    if (if_a.fifo_rd_en) begin
      if_a.fifo_dout <= mem_a[rd_a[3:0]];
      rd_a   <= rd_a + 1;
      pops_a <= pops_a + 1;
    end
  end

  always @(posedge clk) begin
    if (reset) if_b.fifo_data_valid <= 1'b0;
    else       if_b.fifo_data_valid <= if_b.fifo_rd_en;
    if (if_b.fifo_rd_en) begin
      if_b.fifo_dout <= mem_b[rd_b[3:0]];
      rd_b   <= rd_b + 1;
      pops_b <= pops_b + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic cap_tx [256];
  logic cap_busy [256];
  logic cap_done [256];

  task automatic push(input int sel, input logic [7:0] d);
    if (sel == 0) begin
      mem_a[wr_a[3:0]] = d;
      wr_a++;
    end else begin
      mem_b[wr_b[3:0]] = d;
      wr_b++;
    end
  endtask

  // {tx, busy, tx_done, fifo_rd_en}
  function automatic logic [3:0] probe(input int sel);
    if (sel == 0) return {tx_a, busy_a, done_a, if_a.fifo_rd_en};
    return {tx_b, busy_b, done_b, if_b.fifo_rd_en};
  endfunction

  // Expected tx level for bit period b of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input logic odd, input int b);
    logic [7:0] s;
    if (b == 0) return 1'b0;
    if (b <= 8) begin
      s = d >> (b - 1);
      return s[0];
    end
    if (ParEn == 1 && b == 9) return (^d) ^ odd;
    return 1'b1;
  endfunction

  // Waits (bounded) for the start bit, then records len samples, sample 0 being the first start cycle.
  task automatic capture(input int sel, input int len, output bit found);
    logic [3:0] p;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      p = probe(sel);
      if (p[3] == 1'b0) found = 1'b1;
    end
    if (found) begin
      for (int n = 0; n < len; n++) begin
        if (n > 0) @(negedge clk);
        p = probe(sel);
        cap_tx[8'(n)]   = p[3];
        cap_busy[8'(n)] = p[2];
        cap_done[8'(n)] = p[1];
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] p;
    int bad;
    repeat (3) @(negedge clk);
    p = probe(0);
    checks++;
    if (p !== 4'b1000) begin
      errors++;
      $display("FAIL reset_a: tx/busy/done/rd_en=%b, want 1000", p);
    end
    p = probe(1);
    checks++;
    if (p !== 4'b1000) begin
      errors++;
      $display("FAIL reset_b: tx/busy/done/rd_en=%b, want 1000", p);
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      p = probe(0);
      if (p !== 4'b1000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_empty: %0d bad cycles of 50, want 0", bad);
    end
    checks++;
    if (pops_a !== 0) begin
      errors++;
      $display("FAIL idle_no_rd: rd_en pulses=%0d, want 0", pops_a);
    end
  endtask

  task automatic test_frame_a5();
    bit found;
    logic [3:0] got, want;
    logic [8:0] seq;
    int p0, ndone, done_at, nbusy;
    p0 = pops_a;
    push(0, 8'hA5);
    capture(0, Fl0 + 1, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL a5_start: no start bit within 40 cycles, want one");
      return;
    end
    for (int b = 0; b < Fl0 / Cpb; b++) begin
      got  = {cap_tx[8'(b*4+3)], cap_tx[8'(b*4+2)], cap_tx[8'(b*4+1)], cap_tx[8'(b*4)]};
      want = {4{exp_bit(8'hA5, 1'b0, b)}};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL a5_bit%0d: tx samples=%b, want %b", b, got, want);
      end
    end
    for (int b = 0; b < 9; b++) seq[b] = cap_tx[8'(b*4+2)];
    checks++;
    if (seq !== 9'b101001010) begin
      errors++;
      $display("FAIL a5_seq: start+data=%b, want 101001010", seq);
    end
    ndone = 0; done_at = -1; nbusy = 0;
    for (int n = 0; n <= Fl0; n++) begin
      if (cap_done[8'(n)] === 1'b1) begin ndone++; done_at = n; end
      if (n < Fl0 && cap_busy[8'(n)] === 1'b1) nbusy++;
    end
    checks++;
    if (ndone !== 1 || done_at !== Fl0 - 1) begin
      errors++;
      $display("FAIL a5_done: pulses=%0d at %0d, want 1 at %0d", ndone, done_at, Fl0 - 1);
    end
    checks++;
    if (nbusy !== Fl0 || cap_busy[8'(Fl0)] !== 1'b0 || cap_tx[8'(Fl0)] !== 1'b1) begin
      errors++;
      $display("FAIL a5_busy: busy cycles=%0d after=%b tx=%b, want %0d 0 1", nbusy,
               cap_busy[8'(Fl0)], cap_tx[8'(Fl0)], Fl0);
    end
    checks++;
    if (pops_a - p0 !== 1) begin
      errors++;
      $display("FAIL a5_rd: rd_en pulses=%0d, want 1", pops_a - p0);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    logic [3:0] got, want;
    logic [7:0] d1, d2;
    logic [2:0] gap;
    int p0, ndone, off;
    p0 = pops_a;
    push(0, 8'h00);
    push(0, 8'hFF);
    capture(0, 2 * Fl0 + 3, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL b2b_start: no start bit within 40 cycles, want one");
      return;
    end
    off = Fl0 + 2;
    for (int b = 0; b < Fl0 / Cpb; b++) begin
      got  = {cap_tx[8'(b*4+3)], cap_tx[8'(b*4+2)], cap_tx[8'(b*4+1)], cap_tx[8'(b*4)]};
      want = {4{exp_bit(8'h00, 1'b0, b)}};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b_f1_bit%0d: tx samples=%b, want %b", b, got, want);
      end
      got  = {cap_tx[8'(off+b*4+3)], cap_tx[8'(off+b*4+2)],
              cap_tx[8'(off+b*4+1)], cap_tx[8'(off+b*4)]};
      want = {4{exp_bit(8'hFF, 1'b0, b)}};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL b2b_f2_bit%0d: tx samples=%b, want %b", b, got, want);
      end
    end
    for (int i = 0; i < 8; i++) begin
      d1[i] = cap_tx[8'((i+1)*4+2)];
      d2[i] = cap_tx[8'(off+(i+1)*4+2)];
    end
    checks++;
    if (d1 !== 8'h00 || d2 !== 8'hFF) begin
      errors++;
      $display("FAIL b2b_data: got %h %h, want 00 ff", d1, d2);
    end
    gap = {cap_tx[8'(Fl0+2)], cap_tx[8'(Fl0+1)], cap_tx[8'(Fl0)]};
    checks++;
    if (gap !== 3'b011) begin
      errors++;
      $display("FAIL b2b_gap: tx after stop (newest first)=%b, want 011", gap);
    end
    ndone = 0;
    for (int n = 0; n < 2 * Fl0 + 3; n++) if (cap_done[8'(n)] === 1'b1) ndone++;
    checks++;
    if (ndone !== 2 || cap_done[8'(Fl0-1)] !== 1'b1 || cap_done[8'(off+Fl0-1)] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: pulses=%0d, want 2 at end of each frame", ndone);
    end
    checks++;
    if (pops_a - p0 !== 2) begin
      errors++;
      $display("FAIL b2b_rd: rd_en pulses=%0d, want 2", pops_a - p0);
    end
  endtask

  task automatic test_stop2();
    bit found;
    logic [3:0] got, want;
    logic [7:0] stop_win, d;
    int ndone, done_at;
    push(1, 8'h3C);
    capture(1, Fl1 + 1, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stop2_start: no start bit within 40 cycles, want one");
      return;
    end
    for (int b = 0; b < Fl1 / Cpb; b++) begin
      got  = {cap_tx[8'(b*4+3)], cap_tx[8'(b*4+2)], cap_tx[8'(b*4+1)], cap_tx[8'(b*4)]};
      want = {4{exp_bit(8'h3C, 1'b1, b)}};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stop2_bit%0d: tx samples=%b, want %b", b, got, want);
      end
    end
    for (int i = 0; i < 8; i++) begin
      stop_win[i] = cap_tx[8'(Fl1-8+i)];
      d[i]        = cap_tx[8'((i+1)*4+2)];
    end
    checks++;
    if (stop_win !== 8'hFF || d !== 8'h3C) begin
      errors++;
      $display("FAIL stop2_window: stop=%b data=%h, want 11111111 3c", stop_win, d);
    end
    ndone = 0; done_at = -1;
    for (int n = 0; n <= Fl1; n++) if (cap_done[8'(n)] === 1'b1) begin ndone++; done_at = n; end
    checks++;
    if (ndone !== 1 || done_at !== Fl1 - 1 || cap_busy[8'(Fl1)] !== 1'b0) begin
      errors++;
      $display("FAIL stop2_done: pulses=%0d at %0d busy_after=%b, want 1 at %0d busy 0",
               ndone, done_at, cap_busy[8'(Fl1)], Fl1 - 1);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit found;
    logic [3:0] got;
    int done_at;
    // Even parity of 0x01 is 1.
    push(0, 8'h01);
    capture(0, Fl0 + 1, found);
    got = {cap_tx[8'(39)], cap_tx[8'(38)], cap_tx[8'(37)], cap_tx[8'(36)]};
    done_at = -1;
    for (int n = 0; n <= Fl0; n++) if (cap_done[8'(n)] === 1'b1) done_at = n;
    checks++;
    if (!found || got !== 4'b1111 || done_at !== 43) begin
      errors++;
      $display("FAIL parity_even_01: found=%b parity=%b done_at=%0d, want 1 1111 43",
               found, got, done_at);
    end
    // Odd parity of 0xA5 (four ones) is 1; this instance has two stop bits.
    push(1, 8'hA5);
    capture(1, Fl1 + 1, found);
    got = {cap_tx[8'(39)], cap_tx[8'(38)], cap_tx[8'(37)], cap_tx[8'(36)]};
    done_at = -1;
    for (int n = 0; n <= Fl1; n++) if (cap_done[8'(n)] === 1'b1) done_at = n;
    checks++;
    if (!found || got !== 4'b1111 || done_at !== 47) begin
      errors++;
      $display("FAIL parity_odd_a5: found=%b parity=%b done_at=%0d, want 1 1111 47",
               found, got, done_at);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit found;
    logic [3:0] p;
    int p0, bad;
    p0 = pops_a;
    push(0, 8'h55);
    // Samples 16..19 are data bit 3; stop after sample 17.
    capture(0, 18, found);
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rstmid_start: no start bit within 40 cycles, want one");
      return;
    end
    reset = 1'b1;
    #1;
    p = probe(0);
    checks++;
    if (p !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_immediate: tx/busy/done/rd_en=%b, want 1000", p);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      p = probe(0);
      if (p !== 4'b1000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rstmid_no_resend: %0d non-idle cycles after release, want 0", bad);
    end
    checks++;
    if (pops_a - p0 !== 1) begin
      errors++;
      $display("FAIL rstmid_rd: rd_en pulses=%0d, want 1", pops_a - p0);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_stop2();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
